tdc_frame_rx: RTL and testbench
===============================

TDC_FRAME_RX -- requirements
Module: tdc_frame_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104, meaning clk cycles per UART bit period (minimum 4).
REQ-002 Parameter TIMEOUT_BITS, default 40, meaning maximum idle bit periods allowed between bytes inside a frame.
REQ-003 clk  input  1  the single clock; all logic runs on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 rx  input  1  UART serial line, 8N1, idle high, asynchronous to clk.
REQ-006 meas_data  output  16  last accepted TDC measurement.
REQ-007 meas_valid  output  1  one-cycle pulse; meas_data updated in the same cycle.
REQ-008 frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-009 chk_err  output  1  one-cycle pulse; checksum mismatch, frame discarded.
REQ-010 busy  output  1  high while a frame is being assembled (assembler not in F_SYNC).

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; all further logic uses only the synchronized rx.
REQ-012 Byte layer states SHALL be IDLE, START, DATA, STOP and BREAK.
REQ-013 IDLE: synchronized rx=0 -> START, bit counter cleared.
REQ-014 START: at cycle CLKS_PER_BIT/2-1 sample rx; 1 -> IDLE (glitch, no error), 0 -> DATA.
REQ-015 DATA: sample every CLKS_PER_BIT cycles (mid-bit); 8 bits, LSB first; after bit 7 -> STOP.
REQ-016 STOP: sample after CLKS_PER_BIT cycles; 1 -> byte_valid pulse, IDLE; 0 -> frame_err pulse, no byte, BREAK.
REQ-017 BREAK: stay until synchronized rx=1, then IDLE; no new start is detected while in BREAK.
REQ-018 Frame format SHALL be SYNC (0xA5), HI, LO, CHK, where CHK = 0xA5 XOR HI XOR LO.
REQ-019 Assembler states SHALL be F_SYNC, F_HI, F_LO and F_CHK.
REQ-020 F_SYNC: byte 0xA5 -> F_HI; any other byte is dropped silently.
REQ-021 F_HI: capture HI, -> F_LO.
REQ-022 F_LO: capture LO, -> F_CHK.
REQ-023 F_CHK: match -> meas_data={HI,LO}, meas_valid pulse, F_SYNC; mismatch -> chk_err pulse, meas_data held, F_SYNC.
REQ-024 meas_valid SHALL assert exactly 1 cycle after the CHK stop-bit sample cycle.
REQ-025 frame_err in any assembler state other than F_SYNC SHALL return the assembler to F_SYNC, discarding partial data.
REQ-026 Timeout: in F_HI, F_LO or F_CHK, TIMEOUT_BITS*CLKS_PER_BIT cycles with no byte_valid -> F_SYNC, no error pulse.
REQ-027 The timeout counter SHALL reset on every byte_valid and saturate, never wrap.
REQ-028 A byte whose value is 0xA5 in F_HI, F_LO or F_CHK SHALL be treated as data, not as a resync.
REQ-029 At most one of meas_valid, chk_err and frame_err SHALL assert in any cycle.

Reset
REQ-030 rst SHALL clear state asynchronously: byte layer IDLE, assembler F_SYNC, synchronizer flops =1, counters 0.
REQ-031 Reset values of all outputs SHALL be: meas_data=0, meas_valid=0, frame_err=0, chk_err=0, busy=0.
REQ-032 Reset asserted mid-byte or mid-frame SHALL discard all partial data; the first valid frame after release SHALL decode normally.

Structure
REQ-033 Package tdc_uart_pkg SHALL hold SYNC_BYTE (8'hA5), the byte-layer state enum and the assembler state enum.
REQ-034 Sub-module uart_rx_byte SHALL implement REQ-011..REQ-017, outputting byte_data[7:0], byte_valid and frame_err.
REQ-035 tdc_frame_rx SHALL instantiate uart_rx_byte and contain only the assembler, checksum and timeout logic.

Verification (CLKS_PER_BIT=8, TIMEOUT_BITS=40)
REQ-036 Good frame: send A5 12 34 83 -> one meas_valid, meas_data=0x1234, no error pulses.
REQ-037 Bad checksum: send A5 12 34 00 -> chk_err once, meas_data holds its previous value, busy=0 afterward.
REQ-038 Glitch and stop error: 3-cycle low pulse on rx -> no activity; byte 0x55 with stop bit low -> frame_err once; line held low 50 bits then A5 00 01 A4 -> meas_data=0x0001.
REQ-039 Resync: send 00 A5 A5 FF 5A, where 00 is dropped and the frame is A5,A5,FF,5A with CHK=A5^A5^FF=FF -> chk_err once (5A != FF); then send A5 A5 FF FF -> meas_data=0xA5FF.
REQ-040 Timeout: send A5 12, wait 45 bit periods, send A5 00 02 A7 -> meas_data=0x0002 and busy dropped at the timeout.
REQ-041 Reset mid-frame: send A5 12, pulse rst, send A5 AB CD C3 -> meas_data=0xABCD, exactly one meas_valid.

Source files
------------

// File: rtl/tdc_uart_pkg.sv
// Shared constants, state encodings and checksum helper for the TDC frame receiver.
package tdc_uart_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } byte_state_e;

  typedef enum logic [1:0] {
    F_SYNC = 2'd0,
    F_HI   = 2'd1,
    F_LO   = 2'd2,
    F_CHK  = 2'd3
  } frame_state_e;

  function automatic logic [7:0] frame_chk(input logic [7:0] hi, input logic [7:0] lo);
    return SYNC_BYTE ^ hi ^ lo;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: input synchronizer, mid-bit sampling, stop-bit check and
// break handling. byte_valid/frame_err pulse in the stop-bit sample cycle.
module uart_rx_byte
  import tdc_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic        rx_meta_q, rx_meta_d;
  logic        rx_sync_q, rx_sync_d;
  byte_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        bit_end_s;

  // State, counter and synchronizer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_sync_q <= rx_sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  assign bit_end_s = (cnt_q == BIT_LAST);

  // Next-state, bit sampling and byte-level strobes
  always_comb begin
    rx_meta_d  = rx;
    rx_sync_d  = rx_meta_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_sync_q) begin
          state_d = START;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = rx_sync_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          cnt_d = '0;
          if (rx_sync_q) begin
            byte_valid = 1'b1;
            state_d    = IDLE;
          end else begin
            frame_err = 1'b1;
            state_d   = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // A held-low line must return high before a new start bit is honoured
      BREAK: begin
        if (rx_sync_q) begin
          state_d = IDLE;
        end else begin
          state_d = BREAK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_data = shift_q;

endmodule

// File: rtl/tdc_frame_rx.sv
// TDC measurement frame receiver: assembles SYNC/HI/LO/CHK frames from the UART
// byte stream, verifies the checksum and abandons stalled frames after a timeout.
module tdc_frame_rx
  import tdc_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [15:0] meas_data,
  output logic        meas_valid,
  output logic        frame_err,
  output logic        chk_err,
  output logic        busy
);

  localparam int TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TMO_W     = $clog2(TMO_LIMIT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TMO_LIMIT);

  logic [7:0]   byte_data_s;
  logic         byte_valid_s;
  logic         byte_ferr_s;

  frame_state_e fstate_q, fstate_d;
  logic [7:0]   hi_q, hi_d;
  logic [7:0]   lo_q, lo_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [15:0]  meas_data_q, meas_data_d;
  logic         meas_valid_q, meas_valid_d;
  logic         frame_err_q, frame_err_d;
  logic         chk_err_q, chk_err_d;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .byte_data (byte_data_s),
    .byte_valid(byte_valid_s),
    .frame_err (byte_ferr_s)
  );

  // Assembler state, captured fields, timeout counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fstate_q     <= F_SYNC;
      hi_q         <= 8'h00;
      lo_q         <= 8'h00;
      tmo_q        <= '0;
      meas_data_q  <= 16'h0000;
      meas_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      chk_err_q    <= 1'b0;
    end else begin
      fstate_q     <= fstate_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      tmo_q        <= tmo_d;
      meas_data_q  <= meas_data_d;
      meas_valid_q <= meas_valid_d;
      frame_err_q  <= frame_err_d;
      chk_err_q    <= chk_err_d;
    end
  end

  // Frame assembly, checksum verification and timeout handling
  always_comb begin
    fstate_d     = fstate_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    meas_data_d  = meas_data_q;
    meas_valid_d = 1'b0;
    chk_err_d    = 1'b0;
    frame_err_d  = byte_ferr_s;

    // Counter saturates so a long stall can never wrap back below the limit
    if ((fstate_q == F_SYNC) || byte_valid_s) begin
      tmo_d = '0;
    end else if (tmo_q != TMO_MAX) begin
      tmo_d = tmo_q + 1'b1;
    end else begin
      tmo_d = tmo_q;
    end

    if (byte_ferr_s) begin
      fstate_d = F_SYNC;
    end else if (byte_valid_s) begin
      case (fstate_q)
        F_SYNC: fstate_d = (byte_data_s == SYNC_BYTE) ? F_HI : F_SYNC;
        F_HI: begin
          hi_d     = byte_data_s;
          fstate_d = F_LO;
        end
        F_LO: begin
          lo_d     = byte_data_s;
          fstate_d = F_CHK;
        end
        F_CHK: begin
          if (byte_data_s == frame_chk(hi_q, lo_q)) begin
            meas_data_d  = {hi_q, lo_q};
            meas_valid_d = 1'b1;
          end else begin
            chk_err_d = 1'b1;
          end
          fstate_d = F_SYNC;
        end
        default: fstate_d = F_SYNC;
      endcase
    end else if ((fstate_q != F_SYNC) && (tmo_q == TMO_MAX)) begin
      fstate_d = F_SYNC;
    end else begin
      fstate_d = fstate_q;
    end
  end

  assign meas_data  = meas_data_q;
  assign meas_valid = meas_valid_q;
  assign frame_err  = frame_err_q;
  assign chk_err    = chk_err_q;
  assign busy       = (fstate_q != F_SYNC);

endmodule

// File: tb/tb_tdc_frame_rx.sv
// Self-checking bench for tdc_frame_rx: frame vector table plus directed corner sequences,
// with an event scoreboard matching every output pulse against queued expectations.
module tb_tdc_frame_rx;

  localparam int CPB = 8;
  localparam int TMO_BITS = 40;
  localparam logic [2:0] K_MEAS = 3'b001;
  localparam logic [2:0] K_CHK  = 3'b010;
  localparam logic [2:0] K_FERR = 3'b100;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [15:0] meas_data;
  logic        meas_valid;
  logic        frame_err;
  logic        chk_err;
  logic        busy;

  typedef struct {
    logic [2:0]  kind;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] bytes;
    logic [2:0]  kind;
    logic [15:0] md;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[6];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  tdc_frame_rx #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_BITS(TMO_BITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .meas_data (meas_data),
    .meas_valid(meas_valid),
    .frame_err (frame_err),
    .chk_err   (chk_err),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  // Scoreboard: every output pulse must match the next queued expectation
  always @(negedge clk) begin
    if (!rst && (meas_valid || chk_err || frame_err)) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_event: got kind %b data 0x%h, expected no event",
                 {frame_err, chk_err, meas_valid}, meas_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_kind", {29'd0, frame_err, chk_err, meas_valid}, {29'd0, mon_e.kind});
        if (mon_e.kind == K_MEAS) check("event_meas_data", {16'd0, meas_data}, {16'd0, mon_e.data});
      end
    end
  end

  task automatic expect_ev(input logic [2:0] kind, input logic [15:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_bit);
    send_bit(1'b1);
  endtask

  task automatic send_frame(input logic [31:0] f);
    send_byte(f[31:24], 1'b1);
    send_byte(f[23:16], 1'b1);
    send_byte(f[15:8], 1'b1);
    send_byte(f[7:0], 1'b1);
  endtask

  // Wait (bounded) for all expected events, then linger to catch extras
  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (2 * CPB) @(negedge clk);
    check({name, "_drain"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'hA5123483, K_MEAS, 16'h1234};
    vecs[1] = '{32'hA5123400, K_CHK,  16'h1234};
    vecs[2] = '{32'hA5FF005A, K_MEAS, 16'hFF00};
    vecs[3] = '{32'hA50000A5, K_MEAS, 16'h0000};
    vecs[4] = '{32'hA5DEADD6, K_MEAS, 16'hDEAD};
    vecs[5] = '{32'hA5DEADD7, K_CHK,  16'hDEAD};

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_meas_data", {16'd0, meas_data}, 32'd0);
    check("rst_meas_valid", {31'd0, meas_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_chk_err", {31'd0, chk_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      expect_ev(vecs[v].kind, vecs[v].md);
      send_frame(vecs[v].bytes);
      drain($sformatf("vec%0d", v));
      check($sformatf("vec%0d_meas_data", v), {16'd0, meas_data}, {16'd0, vecs[v].md});
      check($sformatf("vec%0d_busy", v), {31'd0, busy}, 32'd0);
    end

    // Short low glitch must not start a byte
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (5 * CPB) @(negedge clk);
    check("glitch_busy", {31'd0, busy}, 32'd0);
    drain("glitch");

    // Stop bit low, then line held low 50 bit periods (break)
    expect_ev(K_FERR, 16'h0000);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(i[0] ? 1'b0 : 1'b1);
    send_bit(1'b0);
    repeat (50) send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    drain("stop_err");
    check("stop_err_busy", {31'd0, busy}, 32'd0);
    expect_ev(K_MEAS, 16'h0001);
    send_frame(32'hA50001A4);
    drain("after_break");
    check("after_break_meas_data", {16'd0, meas_data}, 32'h0001);

    // Framing error mid-frame discards partial data
    send_byte(8'hA5, 1'b1);
    send_byte(8'h12, 1'b1);
    check("mid_ferr_busy_before", {31'd0, busy}, 32'd1);
    expect_ev(K_FERR, 16'h0000);
    send_byte(8'h34, 1'b0);
    send_bit(1'b1);
    check("mid_ferr_busy_after", {31'd0, busy}, 32'd0);
    send_byte(8'h34, 1'b1);
    send_byte(8'h83, 1'b1);
    drain("mid_ferr");
    expect_ev(K_MEAS, 16'h0FF0);
    send_frame(32'hA50FF05A);
    drain("mid_ferr_recover");
    check("mid_ferr_meas_data", {16'd0, meas_data}, 32'h0FF0);

    // Resync: leading junk dropped, 0xA5 inside a frame is data
    expect_ev(K_CHK, 16'h0000);
    send_byte(8'h00, 1'b1);
    send_frame(32'hA5A5FF5A);
    drain("resync_chk");
    check("resync_hold", {16'd0, meas_data}, 32'h0FF0);
    check("resync_busy", {31'd0, busy}, 32'd0);
    expect_ev(K_MEAS, 16'hA5FF);
    send_frame(32'hA5A5FFFF);
    drain("resync_good");
    check("resync_meas_data", {16'd0, meas_data}, 32'hA5FF);

    // Timeout abandons a stalled frame silently
    send_byte(8'hA5, 1'b1);
    send_byte(8'h12, 1'b1);
    repeat (30 * CPB) @(negedge clk);
    check("tmo_busy_before", {31'd0, busy}, 32'd1);
    repeat (15 * CPB) @(negedge clk);
    check("tmo_busy_after", {31'd0, busy}, 32'd0);
    expect_ev(K_MEAS, 16'h0002);
    send_frame(32'hA50002A7);
    drain("timeout");
    check("tmo_meas_data", {16'd0, meas_data}, 32'h0002);

    // Reset mid-frame
    send_byte(8'hA5, 1'b1);
    send_byte(8'h12, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_meas_data", {16'd0, meas_data}, 32'd0);
    rx  = 1'b1;
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    expect_ev(K_MEAS, 16'hABCD);
    send_frame(32'hA5ABCDC3);
    drain("rst_mid");
    check("rst_mid_final", {16'd0, meas_data}, 32'hABCD);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
